// File: rtl/cam_capture_seq.sv
// Camera capture sequencer: exposure timer, sensor readout, 2 bpp ordered-dither
// quantisation against a 4x4x3 threshold matrix, and Game Boy tile packing.
module cam_capture_seq #(
  parameter int unsigned PRESCALE      = 16,
  parameter int unsigned FINISH_CYCLES = 4,
  parameter logic [9:0]  MTX_BASE      = 10'h200
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  input  logic        Cam_Capture,
  input  logic [7:0]  Reg_A001,
  input  logic [7:0]  Reg_A002,
  input  logic [7:0]  Reg_A003,
  output logic        Pix_Start,
  input  logic        Pix_Valid,
  input  logic [7:0]  Pix_Data,
  output logic        Pix_Ready,
  output logic [9:0]  Mtx_Addr,
  input  logic [7:0]  Mtx_Data,
  output logic        Fb_We,
  output logic [11:0] Fb_Addr,
  output logic [7:0]  Fb_Data,
  output logic        Sig_CamCaptureFinish,
  output logic        Busy
);

  localparam logic [15:0] PreLast = 16'(PRESCALE - 1);
  localparam logic [7:0]  FinLast = 8'(FINISH_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StExpose,
    StPixWait,
    StTh0,
    StTh1,
    StTh2,
    StClass,
    StWrLo,
    StWrHi,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic        cap_prev_q;
  logic        inv_q, inv_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] pre_q, pre_d;
  logic [6:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  t0_q, t0_d;
  logic [7:0]  t1_q, t1_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  fin_q, fin_d;
  logic        pix_start_q, pix_start_d;

  logic        cap_rise;
  logic [9:0]  mtx_idx;
  logic [9:0]  mtx_row;
  logic [1:0]  cls;
  logic        unused_a001;

  assign unused_a001 = ^Reg_A001[7:1];
  assign cap_rise    = Cam_Capture & ~cap_prev_q;

  // Threshold triple offset for the current pixel: ((y%4)*4 + x%4) * 3.
  assign mtx_idx = {6'd0, y_q[1:0], x_q[1:0]};
  assign mtx_row = mtx_idx + {mtx_idx[8:0], 1'b0};

  // Classify the latched pixel; t2 is taken straight from the BRAM read port.
  always_comb begin
    if (p_q < t0_q) begin
      cls = 2'd3;
    end else if (p_q < t1_q) begin
      cls = 2'd2;
    end else if (p_q < Mtx_Data) begin
      cls = 2'd1;
    end else begin
      cls = 2'd0;
    end
    if (inv_q) begin
      cls = ~cls;
    end
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    state_d     = state_q;
    inv_d       = inv_q;
    exp_d       = exp_q;
    pre_d       = pre_q;
    x_d         = x_q;
    y_d         = y_q;
    p_d         = p_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    fin_d       = fin_q;
    pix_start_d = 1'b0;

    Pix_Ready            = 1'b0;
    Mtx_Addr             = 10'd0;
    Fb_We                = 1'b0;
    Fb_Addr              = 12'd0;
    Fb_Data              = 8'd0;
    Sig_CamCaptureFinish = 1'b0;
    Busy                 = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (cap_rise) begin
          inv_d = Reg_A001[0];
          exp_d = {Reg_A002, Reg_A003};
          pre_d = 16'd0;
          x_d   = 7'd0;
          y_d   = 7'd0;
          lo_d  = 8'd0;
          hi_d  = 8'd0;
          fin_d = 8'd0;
          if ({Reg_A002, Reg_A003} == 16'd0) begin
            state_d     = StPixWait;
            pix_start_d = 1'b1;
          end else begin
            state_d = StExpose;
          end
        end
      end

      StExpose: begin
        if (!Cam_Capture) begin
          state_d = StIdle;
        end else if (pre_q == PreLast) begin
          pre_d = 16'd0;
          exp_d = exp_q - 16'd1;
          if (exp_q == 16'd1) begin
            state_d     = StPixWait;
            pix_start_d = 1'b1;
          end
        end else begin
          pre_d = pre_q + 16'd1;
        end
      end

      StPixWait: begin
        Pix_Ready = 1'b1;
        if (!Cam_Capture) begin
          state_d = StIdle;
        end else if (Pix_Valid) begin
          p_d     = Pix_Data;
          state_d = StTh0;
        end
      end

      StTh0: begin
        Mtx_Addr = MTX_BASE + mtx_row;
        state_d  = Cam_Capture ? StTh1 : StIdle;
      end

      StTh1: begin
        Mtx_Addr = MTX_BASE + mtx_row + 10'd1;
        t0_d     = Mtx_Data;
        state_d  = Cam_Capture ? StTh2 : StIdle;
      end

      StTh2: begin
        Mtx_Addr = MTX_BASE + mtx_row + 10'd2;
        t1_d     = Mtx_Data;
        state_d  = Cam_Capture ? StClass : StIdle;
      end

      StClass: begin
        if (!Cam_Capture) begin
          state_d = StIdle;
        end else begin
          // MSB first: pixel x%8 == 0 ends up in bit 7.
          lo_d = {lo_q[6:0], cls[0]};
          hi_d = {hi_q[6:0], cls[1]};
          if (x_q[2:0] == 3'd7) begin
            state_d = StWrLo;
          end else begin
            x_d     = x_q + 7'd1;
            state_d = StPixWait;
          end
        end
      end

      StWrLo: begin
        Fb_We   = 1'b1;
        Fb_Addr = {y_q[6:3], x_q[6:3], y_q[2:0], 1'b0};
        Fb_Data = lo_q;
        state_d = Cam_Capture ? StWrHi : StIdle;
      end

      StWrHi: begin
        Fb_We   = 1'b1;
        Fb_Addr = {y_q[6:3], x_q[6:3], y_q[2:0], 1'b1};
        Fb_Data = hi_q;
        if (!Cam_Capture) begin
          state_d = StIdle;
        end else if (x_q == 7'd127 && y_q == 7'd111) begin
          fin_d   = 8'd0;
          state_d = StFinish;
        end else begin
          if (x_q == 7'd127) begin
            x_d = 7'd0;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 7'd1;
          end
          state_d = StPixWait;
        end
      end

      StFinish: begin
        Sig_CamCaptureFinish = 1'b1;
        if (fin_q == FinLast) begin
          state_d = StIdle;
        end else begin
          fin_d = fin_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign Pix_Start = pix_start_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      state_q     <= StIdle;
      cap_prev_q  <= 1'b0;
      inv_q       <= 1'b0;
      exp_q       <= 16'd0;
      pre_q       <= 16'd0;
      x_q         <= 7'd0;
      y_q         <= 7'd0;
      p_q         <= 8'd0;
      t0_q        <= 8'd0;
      t1_q        <= 8'd0;
      lo_q        <= 8'd0;
      hi_q        <= 8'd0;
      fin_q       <= 8'd0;
      pix_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_prev_q  <= Cam_Capture;
      inv_q       <= inv_d;
      exp_q       <= exp_d;
      pre_q       <= pre_d;
      x_q         <= x_d;
      y_q         <= y_d;
      p_q         <= p_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      fin_q       <= fin_d;
      pix_start_q <= pix_start_d;
    end
  end

endmodule

// File: tb/tb_cam_capture_seq.sv
// Directed bench for cam_capture_seq: exposure timing, dither/packing, full frame,
// abort, reset and no-restart behaviour.
module tb_cam_capture_seq;

  localparam int TapIdx = 8 * 128 + 9;  // pixel x=9, y=8

  logic        sys_clock = 1'b0;
  logic        sys_reset;
  logic        Cam_Capture;
  logic [7:0]  Reg_A001, Reg_A002, Reg_A003;
  logic        Pix_Start, Pix_Valid, Pix_Ready;
  logic [7:0]  Pix_Data;
  logic [9:0]  Mtx_Addr;
  logic [7:0]  Mtx_Data;
  logic        Fb_We;
  logic [11:0] Fb_Addr;
  logic [7:0]  Fb_Data;
  logic        Sig_CamCaptureFinish, Busy;

  int n_vec = 0;
  int n_miss = 0;

  always #5 sys_clock = ~sys_clock;

  cam_capture_seq #(
    .PRESCALE      (16),
    .FINISH_CYCLES (4),
    .MTX_BASE      (10'h200)
  ) dut (
    .sys_clock            (sys_clock),
    .sys_reset            (sys_reset),
    .Cam_Capture          (Cam_Capture),
    .Reg_A001             (Reg_A001),
    .Reg_A002             (Reg_A002),
    .Reg_A003             (Reg_A003),
    .Pix_Start            (Pix_Start),
    .Pix_Valid            (Pix_Valid),
    .Pix_Data             (Pix_Data),
    .Pix_Ready            (Pix_Ready),
    .Mtx_Addr             (Mtx_Addr),
    .Mtx_Data             (Mtx_Data),
    .Fb_We                (Fb_We),
    .Fb_Addr              (Fb_Addr),
    .Fb_Data              (Fb_Data),
    .Sig_CamCaptureFinish (Sig_CamCaptureFinish),
    .Busy                 (Busy)
  );

  // Threshold BRAM: one-cycle read latency.
  logic [7:0] mtx_mem [1024];
  always @(posedge sys_clock) Mtx_Data <= mtx_mem[Mtx_Addr];

  // Sensor model and output monitor.
  logic        mon_clr;
  int          pat_mode;
  int          pix_idx, wr_cnt, fin_cnt, tap;
  logic [11:0] last_addr;
  logic [7:0]  fb_mem [4096];
  logic [9:0]  ma [3];

  always_comb begin
    if (pat_mode == 0) begin
      case (pix_idx % 4)
        0:       Pix_Data = 8'h10;
        1:       Pix_Data = 8'h50;
        2:       Pix_Data = 8'h90;
        default: Pix_Data = 8'hD0;
      endcase
    end else begin
      Pix_Data = (pix_idx == TapIdx) ? 8'h18 : 8'hFF;
    end
  end

  always @(posedge sys_clock) begin
    if (mon_clr) begin
      pix_idx <= 0;
      wr_cnt  <= 0;
      fin_cnt <= 0;
      tap     <= 0;
    end else begin
      if (Pix_Valid && Pix_Ready) pix_idx <= pix_idx + 1;
      if (Fb_We) begin
        wr_cnt          <= wr_cnt + 1;
        last_addr       <= Fb_Addr;
        fb_mem[Fb_Addr] <= Fb_Data;
      end
      if (Sig_CamCaptureFinish) fin_cnt <= fin_cnt + 1;
      if (Pix_Valid && Pix_Ready && pix_idx == TapIdx) begin
        tap <= 1;
      end else if (tap >= 1 && tap <= 3) begin
        ma[tap-1] <= Mtx_Addr;
        tap       <= tap + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge sys_clock);
    mon_clr = 1'b0;
  endtask

  // Row-0 pattern run with E=0, aborted after the first byte pair.
  task automatic run_pattern(input logic [7:0] a001, input logic [7:0] exp_lo,
                             input logic [7:0] exp_hi);
    int n;
    pat_mode  = 0;
    Reg_A001  = a001;
    Reg_A002  = 8'h00;
    Reg_A003  = 8'h00;
    Pix_Valid = 1'b1;
    fb_mem[0] = 8'h00;
    fb_mem[1] = 8'h00;
    clear_mon();
    Cam_Capture = 1'b1;
    @(negedge sys_clock);
    check("pat_busy", Busy, 1);
    check("pat_ready0", Pix_Ready, 1);
    @(negedge sys_clock);
    check("pat_th0", Mtx_Addr, 10'h200);
    check("pat_ready_th0", Pix_Ready, 0);
    @(negedge sys_clock);
    check("pat_th1", Mtx_Addr, 10'h201);
    @(negedge sys_clock);
    check("pat_th2", Mtx_Addr, 10'h202);
    @(negedge sys_clock);
    check("pat_ready_class", Pix_Ready, 0);
    @(negedge sys_clock);
    check("pat_ready_next", Pix_Ready, 1);
    n = 0;
    while (wr_cnt < 2 && n < 200) begin
      @(negedge sys_clock);
      n++;
    end
    check("pat_wr_timeout", (n < 200), 1);
    Cam_Capture = 1'b0;
    @(negedge sys_clock);
    check("pat_lo", fb_mem[0], exp_lo);
    check("pat_hi", fb_mem[1], exp_hi);
    check("pat_abort_busy", Busy, 0);
    check("pat_no_finish", fin_cnt, 0);
  endtask

  initial begin
    int  n;
    int  h;
    logic busy_ok;

    sys_reset   = 1'b1;
    Cam_Capture = 1'b0;
    Reg_A001    = 8'h00;
    Reg_A002    = 8'h00;
    Reg_A003    = 8'h00;
    Pix_Valid   = 1'b0;
    pat_mode    = 0;
    mon_clr     = 1'b1;
    for (int i = 0; i < 1024; i++) mtx_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mtx_mem[10'h200 + 3*i]     = 8'h40;
      mtx_mem[10'h200 + 3*i + 1] = 8'h80;
      mtx_mem[10'h200 + 3*i + 2] = 8'hC0;
    end
    repeat (3) @(negedge sys_clock);

    check("rst_busy", Busy, 0);
    check("rst_ready", Pix_Ready, 0);
    check("rst_pix_start", Pix_Start, 0);
    check("rst_fb_we", Fb_We, 0);
    check("rst_finish", Sig_CamCaptureFinish, 0);
    check("rst_mtx_addr", Mtx_Addr, 0);
    check("rst_fb_addr", Fb_Addr, 0);
    sys_reset = 1'b0;
    mon_clr   = 1'b0;
    @(negedge sys_clock);

    // Exposure E=2: Pix_Start 32 cycles after entering EXPOSE.
    Reg_A002    = 8'h00;
    Reg_A003    = 8'h02;
    Cam_Capture = 1'b1;
    @(negedge sys_clock);
    check("exp_busy_start", Busy, 1);
    n       = 0;
    busy_ok = 1'b1;
    while (!Pix_Start && n < 100) begin
      if (!Busy) busy_ok = 1'b0;
      @(negedge sys_clock);
      n++;
    end
    check("exp_len", n, 32);
    check("exp_busy_hold", busy_ok, 1);
    check("exp_ready_at_start", Pix_Ready, 1);
    @(negedge sys_clock);
    check("exp_pix_start_pulse", Pix_Start, 0);
    Cam_Capture = 1'b0;
    @(negedge sys_clock);
    check("exp_abort_busy", Busy, 0);
    check("exp_abort_finish", Sig_CamCaptureFinish, 0);

    // Dither and packing, normal then inverted colour.
    run_pattern(8'h00, 8'hAA, 8'hCC);
    run_pattern(8'h01, 8'h55, 8'h33);

    // Reset in the middle of an exposure.
    Reg_A003    = 8'h05;
    Cam_Capture = 1'b1;
    repeat (10) @(negedge sys_clock);
    check("rstmid_busy_before", Busy, 1);
    sys_reset   = 1'b1;
    Cam_Capture = 1'b0;
    @(negedge sys_clock);
    sys_reset = 1'b0;
    check("rstmid_busy", Busy, 0);
    check("rstmid_finish", Sig_CamCaptureFinish, 0);
    @(negedge sys_clock);

    // Full frame of 0xFF with one darker pixel at (9,8) using matrix entry 1.
    mtx_mem[10'h203] = 8'h10;
    mtx_mem[10'h204] = 8'h20;
    mtx_mem[10'h205] = 8'h30;
    pat_mode  = 1;
    Reg_A001  = 8'h00;
    Reg_A002  = 8'h00;
    Reg_A003  = 8'h00;
    Pix_Valid = 1'b1;
    fb_mem[12'h000] = 8'hEE;
    fb_mem[12'h110] = 8'hEE;
    fb_mem[12'h111] = 8'hEE;
    clear_mon();
    Cam_Capture = 1'b1;
    n = 0;
    while (!Sig_CamCaptureFinish && n < 90000) begin
      @(negedge sys_clock);
      n++;
    end
    check("frame_finish_seen", (n < 90000), 1);
    check("frame_busy_in_finish", Busy, 1);
    check("frame_wr_count", wr_cnt, 3584);
    check("frame_last_addr", last_addr, 12'hDFF);
    h = 0;
    while (Sig_CamCaptureFinish && h < 20) begin
      @(negedge sys_clock);
      h++;
    end
    check("frame_finish_len", h, 4);
    check("frame_idle", Busy, 0);
    check("frame_byte0", fb_mem[12'h000], 8'h00);
    check("frame_tap_lo", fb_mem[12'h110], 8'h00);
    check("frame_tap_hi", fb_mem[12'h111], 8'h40);
    check("frame_mtx_k0", ma[0], 10'h203);
    check("frame_mtx_k1", ma[1], 10'h204);
    check("frame_mtx_k2", ma[2], 10'h205);

    // Capture held high after finish must not restart.
    busy_ok = 1'b1;
    repeat (30) begin
      @(negedge sys_clock);
      if (Busy) busy_ok = 1'b0;
    end
    check("no_restart", busy_ok, 1);
    check("no_restart_writes", wr_cnt, 3584);
    check("no_restart_finish", fin_cnt, 4);
    Cam_Capture = 1'b0;
    @(negedge sys_clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
